asconp_iter: RTL and testbench

- Round sequencer and 320-bit state register wrapped around the combinational Ascon permutation datapath (asconp).
- Accepts a state plus a round count (p^12 / p^8 / p^6) from the mode controller.
- Drives the permutation's state inputs and round_cnt each cycle, and registers the permutation's outputs.
- Returns the permuted state through a valid/ready handshake.

---
 rtl/asconp_iter.sv | 97 +++++++++
 tb/tb_asconp_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/asconp_iter.sv
// asconp_iter: round sequencer and 320-bit state register around the combinational asconp datapath, valid/ready in and out
module asconp_iter #(
  parameter int UROL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rounds,
  input  logic [63:0] in_x0,
  input  logic [63:0] in_x1,
  input  logic [63:0] in_x2,
  input  logic [63:0] in_x3,
  input  logic [63:0] in_x4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_x0,
  output logic [63:0] out_x1,
  output logic [63:0] out_x2,
  output logic [63:0] out_x3,
  output logic [63:0] out_x4,
  output logic        err,
  output logic        busy,
  output logic [3:0]  perm_round_cnt,
  output logic [63:0] perm_x0_i,
  output logic [63:0] perm_x1_i,
  output logic [63:0] perm_x2_i,
  output logic [63:0] perm_x3_i,
  output logic [63:0] perm_x4_i,
  input  logic [63:0] perm_x0_o,
  input  logic [63:0] perm_x1_o,
  input  logic [63:0] perm_x2_o,
  input  logic [63:0] perm_x3_o,
  input  logic [63:0] perm_x4_o
);
  localparam logic [3:0] STEP = 4'(UROL);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [63:0] x_q [5];
  logic [63:0] x_d [5];
  logic [3:0]  cnt_q, cnt_d, cnt_nxt;
  logic        err_q, err_d, legal;
  always_comb begin
    legal   = (in_rounds == 4'd12 || in_rounds == 4'd8 || in_rounds == 4'd6) && (in_rounds % STEP == 4'd0);
    cnt_nxt = cnt_q > STEP ? cnt_q - STEP : 4'd0;
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        if (legal) begin
          state_d = RUN;
          cnt_d   = in_rounds;
          x_d     = '{in_x0, in_x1, in_x2, in_x3, in_x4};
        end else begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        x_d     = '{perm_x0_o, perm_x1_o, perm_x2_o, perm_x3_o, perm_x4_o};
        cnt_d   = cnt_nxt;
        state_d = cnt_nxt == 4'd0 ? DONE : RUN;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      x_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      x_q     <= x_d;
    end
  end
  assign in_ready       = state_q == IDLE;
  assign busy           = state_q == RUN;
  assign out_valid      = state_q == DONE;
  assign err            = err_q;
  assign perm_round_cnt = busy ? cnt_q : 4'd0;
  assign perm_x0_i      = x_q[0];
  assign perm_x1_i      = x_q[1];
  assign perm_x2_i      = x_q[2];
  assign perm_x3_i      = x_q[3];
  assign perm_x4_i      = x_q[4];
  assign out_x0         = x_q[0];
  assign out_x1         = x_q[1];
  assign out_x2         = x_q[2];
  assign out_x3         = x_q[3];
  assign out_x4         = x_q[4];
endmodule

// File: tb/tb_asconp_iter.sv
// tb_asconp_iter: scoreboard bench driving a UROL=1 and a UROL=2 build side by side against an Ascon-p reference
module tb_asconp_iter;
  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic [3:0]   in_rounds = 0;
  logic [319:0] in_x = '0;
  logic         out_ready = 1;
  logic         exp_err = 0;
  logic         rchk = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  always #5 clk = ~clk;
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [319:0] rnd(input logic [319:0] s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 ^= 64'(((15 - i) << 4) | i);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 ^= ror(x0, 19) ^ ror(x0, 28);
    x1 ^= ror(x1, 61) ^ ror(x1, 39);
    x2 ^= ror(x2, 1) ^ ror(x2, 6);
    x3 ^= ror(x3, 10) ^ ror(x3, 17);
    x4 ^= ror(x4, 7) ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction
  function automatic logic [319:0] p_ref(input logic [319:0] s, input int n);
    for (int i = 12 - n; i < 12; i++) s = rnd(s, i);
    return s;
  endfunction
  function automatic logic [319:0] perm(input logic [319:0] s, input int r, input int u);
    for (int j = 0; j < u; j++) if (r - j > 0) s = rnd(s, 12 - (r - j));
    return s;
  endfunction
  function automatic bit lg(input int r);
    return r == 12 || r == 8 || r == 6;
  endfunction
  task automatic chk(input int id, input string nm, input logic [319:0] a, input logic [319:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s urol%0d got=%0h want=%0h", nm, id + 1, a, e);
    end
  endtask
  task automatic fail(input int id, input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s urol%0d", nm, id + 1);
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic         ir, ov, er, bz;
    logic [3:0]   prc;
    logic [319:0] ox, pi, po, prev;
    logic         was_hs = 0, was_valid = 0;
    logic [319:0] exp_q[$];
    int           cq[$];
    assign po = perm(pi, int'(prc), g + 1);
    asconp_iter #(.UROL(g + 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir), .in_rounds(in_rounds),
      .in_x0(in_x[319:256]), .in_x1(in_x[255:192]), .in_x2(in_x[191:128]), .in_x3(in_x[127:64]), .in_x4(in_x[63:0]),
      .out_valid(ov), .out_ready(out_ready),
      .out_x0(ox[319:256]), .out_x1(ox[255:192]), .out_x2(ox[191:128]), .out_x3(ox[127:64]), .out_x4(ox[63:0]),
      .err(er), .busy(bz), .perm_round_cnt(prc),
      .perm_x0_i(pi[319:256]), .perm_x1_i(pi[255:192]), .perm_x2_i(pi[191:128]), .perm_x3_i(pi[127:64]), .perm_x4_i(pi[63:0]),
      .perm_x0_o(po[319:256]), .perm_x1_o(po[255:192]), .perm_x2_o(po[191:128]), .perm_x3_o(po[127:64]), .perm_x4_o(po[63:0])
    );
    always @(negedge clk) begin
      if (rchk) begin
        chk(g, "rst_in_ready", ir, 1);
        chk(g, "rst_out_valid", ov, 0);
        chk(g, "rst_busy", bz, 0);
        chk(g, "rst_round_cnt", prc, 0);
        chk(g, "rst_state", pi, 0);
        chk(g, "rst_out_x", ox, 0);
      end
      if (bz) begin
        if (cq.size() == 0) fail(g, "unexpected_run");
        else chk(g, "round_cnt", prc, cq.pop_front());
      end
      if (was_hs) chk(g, "release", {ov, ir}, 2'b01);
      if (ov) begin
        chk(g, "bp_in_ready", ir, 0);
        if (was_valid) chk(g, "hold", ox, prev);
        if (cq.size() != 0) fail(g, "rounds_short");
        if (out_ready) begin
          if (exp_q.size() == 0) fail(g, "spurious_out");
          else chk(g, "state", ox, exp_q.pop_front());
        end
      end
      chk(g, "err", er, exp_err);
      was_hs    = ov && out_ready;
      was_valid = ov && !out_ready;
      prev      = ox;
    end
  end
  task automatic flush();
    g_dut[0].exp_q.delete(); g_dut[0].cq.delete();
    g_dut[1].exp_q.delete(); g_dut[1].cq.delete();
    exp_err = 0;
  endtask
  task automatic do_reset(input int cycles);
    rst = 1;
    repeat (cycles) @(posedge clk);
    #1 rst = 0;
    flush();
    rchk = 1;
    @(negedge clk);
    #1 rchk = 0;
  endtask
  task automatic req(input int n, input logic [319:0] s);
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = g_dut[0].ir && g_dut[1].ir;
    end
    if (!ok) begin
      fail(0, "req_timeout");
      return;
    end
    in_valid = 1; in_rounds = 4'(n); in_x = s;
    @(posedge clk);
    if (lg(n)) begin
      g_dut[0].exp_q.push_back(p_ref(s, n));
      g_dut[1].exp_q.push_back(p_ref(s, n));
      for (int r = n; r > 0; r--) g_dut[0].cq.push_back(r);
      for (int r = n; r > 0; r -= 2) g_dut[1].cq.push_back(r);
    end else exp_err = 1;
    #1 in_valid = 0; in_rounds = 4'($urandom); in_x = {10{$urandom}};
    if (!lg(n)) begin
      @(posedge clk);
      #1 exp_err = 0;
    end
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      ok = g_dut[0].exp_q.size() == 0 && g_dut[1].exp_q.size() == 0;
    end
    if (!ok) fail(0, "done_timeout");
  endtask
  function automatic logic [319:0] rstate();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    int legal_r[3] = '{12, 8, 6};
    int bad_r[5] = '{0, 5, 13, 7, 15};
    bit ok;
    do_reset(2);
    req(12, '0);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      req(legal_r[$urandom_range(0, 2)], rstate());
      wait_done();
    end
    foreach (bad_r[i]) begin
      req(bad_r[i], rstate());
      repeat (2) @(posedge clk);
      req(legal_r[i % 3], rstate());
      wait_done();
    end
    #1 out_ready = 0;
    req(8, rstate());
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = g_dut[0].ov && g_dut[1].ov;
    end
    if (!ok) fail(0, "valid_timeout");
    repeat (20) begin
      @(posedge clk);
      #1 in_valid = 1'($urandom); in_rounds = 4'(legal_r[$urandom_range(0, 2)]); in_x = rstate();
    end
    @(posedge clk);
    #1 in_valid = 0; out_ready = 1;
    wait_done();
    req(12, rstate());
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    flush();
    rchk = 1;
    @(negedge clk);
    #1 rchk = 0;
    repeat (20) @(posedge clk);
    req(6, rstate());
    wait_done();
    for (int i = 0; i < 6; i++) begin
      req(legal_r[$urandom_range(0, 2)], rstate());
      wait_done();
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
